warp_barrier_unit: RTL

- Scheduler-side responder for the barrier_t requests the warp-control unit issues.
- Tracks per-barrier arrival counts and arrived-warp masks, and keeps arrived warps stalled.
- Releases all participants when the last local warp arrives.
- For global barriers, forwards a request to the cluster-level global barrier and releases only when the response returns.

---
 rtl/warp_barrier_unit_pkg.sv | 32 +++
 rtl/warp_barrier_unit_fifo.sv | 59 +++++
 rtl/warp_barrier_unit_rel.sv | 114 +++++++++++
 rtl/warp_barrier_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/warp_barrier_unit_pkg.sv
// Shared types and widths for the warp barrier unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package warp_barrier_unit_pkg;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
    localparam int SIZE_WIDTH   = NW_WIDTH;

    // Barrier request as issued by the warp-control unit.
    typedef struct packed {
        logic                  valid;
        logic [NB_WIDTH-1:0]   id;
        logic                  is_global;
        logic [SIZE_WIDTH-1:0] size_m1;
        logic                  is_noop;
    } barrier_t;

    // Per-barrier state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_GWAIT   = 2'd2;

    // Arrival request forwarded to the cluster-level global barrier.
    typedef struct packed {
        logic [NB_WIDTH-1:0]   id;
        logic [SIZE_WIDTH-1:0] size_m1;
    } gbar_req_t;

endpackage

// File: rtl/warp_barrier_unit_fifo.sv
// Generic small synchronous FIFO (valid/ready on both sides).
// Latency: a pushed entry is poppable the cycle after the push.
// Backpressure: o_push_rdy low when full; entries held until i_pop_rdy.
module warp_barrier_unit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_push_rdy,
    output logic             o_pop_vld,
    output logic [WIDTH-1:0] o_pop_dat,
    input  logic             i_pop_rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign o_push_rdy = (r_cnt != FULL);
    assign o_pop_vld  = (r_cnt != '0);
    assign o_pop_dat  = r_mem[r_rd_ptr];
    assign w_push     = i_push_vld && o_push_rdy;
    assign w_pop      = i_pop_rdy && o_pop_vld;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= nxt(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= nxt(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/warp_barrier_unit_rel.sv
// Release-ordering stage and global-barrier request queue.
// Latency: release pulses 1 cycle after the cause; gbar request 1 cycle after push.
// Backpressure: gbar request holds until i_gbar_req_rdy; extra requests queue in a FIFO.
module warp_barrier_unit_rel
    import warp_barrier_unit_pkg::*;
(
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_loc_rel_vld,
    input  logic [NUM_WARPS-1:0]                i_loc_rel_mask,
    input  logic                                i_rsp_vld,
    input  logic [NB_WIDTH-1:0]                 i_rsp_id,
    input  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] i_masks,
    output logic                                o_gdone_vld,
    output logic [NB_WIDTH-1:0]                 o_gdone_id,
    output logic                                o_release_valid,
    output logic [NUM_WARPS-1:0]                o_release_mask,
    input  logic                                i_gpush_vld,
    input  gbar_req_t                           i_gpush_dat,
    output logic                                o_gbar_req_vld,
    output gbar_req_t                           o_gbar_req_dat,
    input  logic                                i_gbar_req_rdy
);
    // Completed global barriers waiting for a free release slot.
    logic [NUM_BARRIERS-1:0] r_done;
    logic [NUM_BARRIERS-1:0] w_cand;
    logic [NUM_BARRIERS-1:0] w_sel_bit;
    logic                    w_sel_vld;
    logic [NB_WIDTH-1:0]     w_sel_id;
    logic                    r_rel_vld;
    logic [NUM_WARPS-1:0]    r_rel_mask;

    assign w_cand    = r_done | ({NUM_BARRIERS{i_rsp_vld}} & (NUM_BARRIERS'(1) << i_rsp_id));
    assign w_sel_vld = !i_loc_rel_vld && (|w_cand);
    assign w_sel_bit = w_sel_vld ? (NUM_BARRIERS'(1) << w_sel_id) : '0;

    // Lowest-numbered completed barrier takes the slot when no local release claims it.
    always_comb begin
        w_sel_id = '0;
        for (int i = NUM_BARRIERS-1; i >= 0; i--) begin
            if (w_cand[i]) w_sel_id = NB_WIDTH'(i);
        end
    end

    assign o_gdone_vld     = w_sel_vld;
    assign o_gdone_id      = w_sel_id;
    assign o_release_valid = r_rel_vld;
    assign o_release_mask  = r_rel_mask;

    // Register one release per cycle; the local release always wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_done     <= '0;
            r_rel_vld  <= 1'b0;
            r_rel_mask <= '0;
        end else begin
            r_done     <= w_cand & ~w_sel_bit;
            r_rel_vld  <= i_loc_rel_vld | w_sel_vld;
            r_rel_mask <= i_loc_rel_vld ? i_loc_rel_mask :
                          (w_sel_vld ? i_masks[w_sel_id] : '0);
        end
    end

    // Holding register in front of the overflow FIFO keeps request order.
    logic      r_hold_vld;
    gbar_req_t r_hold;
    logic      w_hold_free;
    logic      w_fifo_push;
    logic      w_fifo_rdy;
    logic      w_fifo_vld;
    logic      w_fifo_pop;
    gbar_req_t w_fifo_dat;

    assign w_hold_free    = !r_hold_vld || i_gbar_req_rdy;
    assign w_fifo_pop     = w_hold_free && w_fifo_vld;
    assign w_fifo_push    = i_gpush_vld && !(w_hold_free && !w_fifo_vld);
    assign o_gbar_req_vld = r_hold_vld;
    assign o_gbar_req_dat = r_hold;

    warp_barrier_unit_fifo #(
        .WIDTH ($bits(gbar_req_t)),
        .DEPTH (NUM_BARRIERS)
    ) u_gbar_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push_vld (w_fifo_push),
        .i_push_dat (i_gpush_dat),
        .o_push_rdy (w_fifo_rdy),
        .o_pop_vld  (w_fifo_vld),
        .o_pop_dat  (w_fifo_dat),
        .i_pop_rdy  (w_fifo_pop)
    );

    // Refill the holding register from the FIFO first, then from a new push.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
        end else if (w_hold_free) begin
            if (w_fifo_vld) begin
                r_hold_vld <= 1'b1;
                r_hold     <= w_fifo_dat;
            end else begin
                r_hold_vld <= i_gpush_vld;
                r_hold     <= i_gpush_dat;
            end
        end
    end

    // At most NUM_BARRIERS barriers can be in GWAIT, so the FIFO never overflows.
    a_fifo_no_ovf: assert property (@(posedge i_clk) disable iff (i_reset)
        w_fifo_push |-> w_fifo_rdy);

endmodule

// File: rtl/warp_barrier_unit.sv
// Per-core barrier tracker: stalls arriving warps, releases on last arrival or global response.
// Latency: stall, release and gbar request all visible 1 cycle after the causing input.
// Backpressure: none on requests; gbar requests held/queued until i_gbar_req_ready.
module warp_barrier_unit
    import warp_barrier_unit_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_bar_valid,
    input  logic [NW_WIDTH-1:0]   i_bar_wid,
    input  barrier_t              i_bar_req,
    output logic [NUM_WARPS-1:0]  o_stalled_warps,
    output logic                  o_release_valid,
    output logic [NUM_WARPS-1:0]  o_release_mask,
    output logic                  o_gbar_req_valid,
    output logic [NB_WIDTH-1:0]   o_gbar_req_id,
    output logic [SIZE_WIDTH-1:0] o_gbar_req_size_m1,
    input  logic                  i_gbar_req_ready,
    input  logic                  i_gbar_rsp_valid,
    input  logic [NB_WIDTH-1:0]   i_gbar_rsp_id
);
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] r_mask;
    logic [NUM_BARRIERS-1:0][NW_WIDTH-1:0]  r_count;
    logic [NUM_BARRIERS-1:0][1:0]           r_st;

    logic [NB_WIDTH-1:0]  w_b;
    logic [NUM_WARPS-1:0] w_wbit;
    logic [NW_WIDTH-1:0]  w_target;
    logic w_arrive, w_err_gwait, w_err_stalled, w_accept, w_last;
    logic w_loc_rel, w_gpush, w_rsp_ok, w_gdone_vld;
    logic [NB_WIDTH-1:0]  w_gdone_id;
    gbar_req_t            w_gpush_dat;
    gbar_req_t            w_gq;
    logic                 w_unused;

    assign w_unused      = i_bar_req.valid;
    assign w_b           = i_bar_req.id;
    assign w_wbit        = NUM_WARPS'(1) << i_bar_wid;
    assign w_arrive      = i_bar_valid && !i_bar_req.is_noop;
    assign w_err_gwait   = (r_st[w_b] == ST_GWAIT);
    assign w_err_stalled = |(o_stalled_warps & w_wbit);
    assign w_accept      = w_arrive && !w_err_gwait && !w_err_stalled;
    // A global barrier needs every local warp before it goes to the cluster.
    assign w_target      = i_bar_req.is_global ? NW_WIDTH'(NUM_WARPS-1)
                                               : i_bar_req.size_m1[NW_WIDTH-1:0];
    assign w_last        = (r_count[w_b] == w_target);
    assign w_loc_rel     = w_accept && w_last && !i_bar_req.is_global;
    assign w_gpush       = w_accept && w_last && i_bar_req.is_global;
    assign w_rsp_ok      = i_gbar_rsp_valid && (r_st[i_gbar_rsp_id] == ST_GWAIT);
    assign w_gpush_dat   = '{id: w_b, size_m1: i_bar_req.size_m1};

    // A warp is stalled while it sits in any barrier's arrival mask.
    always_comb begin
        o_stalled_warps = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            o_stalled_warps = o_stalled_warps | r_mask[i];
        end
    end

    // Arrival accounting; a barrier is cleared on local release or when its global release pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mask  <= '0;
            r_count <= '0;
            r_st    <= {NUM_BARRIERS{ST_IDLE}};
        end else begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                if (w_accept && (w_b == NB_WIDTH'(i))) begin
                    if (w_loc_rel) begin
                        r_mask[i]  <= '0;
                        r_count[i] <= '0;
                        r_st[i]    <= ST_IDLE;
                    end else if (w_last) begin
                        r_mask[i]  <= r_mask[i] | w_wbit;
                        r_st[i]    <= ST_GWAIT;
                    end else begin
                        r_mask[i]  <= r_mask[i] | w_wbit;
                        r_count[i] <= r_count[i] + 1'b1;
                        r_st[i]    <= ST_COLLECT;
                    end
                end
                if (w_gdone_vld && (w_gdone_id == NB_WIDTH'(i))) begin
                    r_mask[i]  <= '0;
                    r_count[i] <= '0;
                    r_st[i]    <= ST_IDLE;
                end
            end
        end
    end

    warp_barrier_unit_rel u_rel (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_loc_rel_vld   (w_loc_rel),
        .i_loc_rel_mask  (r_mask[w_b] | w_wbit),
        .i_rsp_vld       (w_rsp_ok),
        .i_rsp_id        (i_gbar_rsp_id),
        .i_masks         (r_mask),
        .o_gdone_vld     (w_gdone_vld),
        .o_gdone_id      (w_gdone_id),
        .o_release_valid (o_release_valid),
        .o_release_mask  (o_release_mask),
        .i_gpush_vld     (w_gpush),
        .i_gpush_dat     (w_gpush_dat),
        .o_gbar_req_vld  (o_gbar_req_valid),
        .o_gbar_req_dat  (w_gq),
        .i_gbar_req_rdy  (i_gbar_req_ready)
    );

    assign o_gbar_req_id      = w_gq.id;
    assign o_gbar_req_size_m1 = w_gq.size_m1;

    a_no_gwait_req: assert property (@(posedge i_clk) disable iff (i_reset)
        w_arrive |-> !w_err_gwait);
    a_no_stalled_req: assert property (@(posedge i_clk) disable iff (i_reset)
        w_arrive |-> !w_err_stalled);
    a_size_range: assert property (@(posedge i_clk) disable iff (i_reset)
        w_arrive |-> (int'(i_bar_req.size_m1) < NUM_WARPS));
    a_rsp_gwait: assert property (@(posedge i_clk) disable iff (i_reset)
        i_gbar_rsp_valid |-> (r_st[i_gbar_rsp_id] == ST_GWAIT));

endmodule
